// File: rtl/regfile_dual_port.sv
// -----------------------------------------------------------------------------
// regfile_dual_port
//
// Purpose:
//   Parametrised register file for the system control path. It has one write
//   port and one independent read port, both of which can be used in the same
//   cycle.
//   - The read is registered and comes with a one-cycle valid strobe.
//   - WR_PROTECT makes chosen entries read-only from the write port.
//   - A rejected access (out-of-range address, or a write to a protected
//     entry) raises a one-cycle Addr_Err pulse on the following cycle.
//   - The low NUM_EXPOSED entries are driven combinationally onto REG_OUT.
//
// Parameters:
//   DATA_WIDTH  - bits per entry
//   REG_NUM     - implemented entries (2 .. 2**ADDR_WIDTH)
//   ADDR_WIDTH  - address bits on both ports
//   NUM_EXPOSED - low entries mirrored on REG_OUT (1 .. REG_NUM)
//   WR_PROTECT  - REG_NUM-bit mask; bit i = 1 makes entry i read-only
//
// Ports:
//   CLK           in   clock, rising edge
//   RST           in   asynchronous active-high reset
//   WrEn          in   write request
//   WrAddr        in   write address
//   WrData        in   write data
//   RdEn          in   read request
//   RdAddr        in   read address
//   RdData        out  registered read data (holds when no read is issued)
//   RdData_Valid  out  one-cycle strobe: RdData was updated this cycle
//   Addr_Err      out  one-cycle strobe: previous-cycle access was rejected
//   REG_OUT       out  entry i on bits [i*DATA_WIDTH +: DATA_WIDTH]
//
// Optional feature (macro REGFILE_PARITY_EN):
//   Each entry stores an even-parity bit that is computed from WrData when the
//   entry is written. Every in-range read checks the stored bit and reports a
//   mismatch on Parity_Err, aligned with RdData_Valid. The test input Par_Flip
//   inverts the parity bit that is stored for the entry written in that cycle.
// -----------------------------------------------------------------------------
module regfile_dual_port #(
   parameter int                DATA_WIDTH  = 8,
   parameter int                REG_NUM     = 12,
   parameter int                ADDR_WIDTH  = 4,
   parameter int                NUM_EXPOSED = 6,
   parameter logic [REG_NUM-1:0] WR_PROTECT = '0
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              WrEn,
   input  logic [ADDR_WIDTH-1:0]             WrAddr,
   input  logic [DATA_WIDTH-1:0]             WrData,
   input  logic                              RdEn,
   input  logic [ADDR_WIDTH-1:0]             RdAddr,
   output logic [DATA_WIDTH-1:0]             RdData,
   output logic                              RdData_Valid,
   output logic                              Addr_Err,
   output logic [NUM_EXPOSED*DATA_WIDTH-1:0] REG_OUT
`ifdef REGFILE_PARITY_EN
   ,
   input  logic                              Par_Flip,
   output logic                              Parity_Err
`endif
);

   // Illegal parameter combinations must stop elaboration.
   if ((NUM_EXPOSED > REG_NUM) || (REG_NUM > (2 ** ADDR_WIDTH)) ||
       (NUM_EXPOSED < 1) || (REG_NUM < 2)) begin : g_param_check
      $error("regfile_dual_port: illegal NUM_EXPOSED/REG_NUM/ADDR_WIDTH combination");
   end

   logic [DATA_WIDTH-1:0] mem_q [REG_NUM];

   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_vld_q,  rd_vld_d;
   logic                  addr_err_q, addr_err_d;

   logic [REG_NUM-1:0]    wr_sel;     // one-hot accepted write target
   logic                  wr_hit;     // write address in range and unprotected
   logic                  rd_hit;     // read address in range
   logic [DATA_WIDTH-1:0] rd_word;    // array word at RdAddr, 0 if out of range

   // Address decoding. Each entry is compared explicitly, so an address at or
   // above REG_NUM matches nothing and is treated as out of range.
   always_comb begin
      wr_sel  = '0;
      wr_hit  = 1'b0;
      rd_hit  = 1'b0;
      rd_word = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (WrAddr == ADDR_WIDTH'(i) && !WR_PROTECT[i]) begin
            wr_sel[i] = WrEn;
            wr_hit    = 1'b1;
         end
         if (RdAddr == ADDR_WIDTH'(i)) begin
            rd_hit  = 1'b1;
            rd_word = mem_q[i];
         end
      end
   end

   // Write port. The read mux samples mem_q before this edge, so a read of the
   // same address in the same cycle returns the old contents.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < REG_NUM; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (wr_sel[i]) begin
               mem_q[i] <= WrData;
            end
         end
      end
   end

   // Read and error next-state logic. RdData holds its last value when no read
   // is issued.
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_vld_d   = 1'b0;
      addr_err_d = (WrEn && !wr_hit) || (RdEn && !rd_hit);
      if (RdEn) begin
         rd_data_d = rd_word;
         rd_vld_d  = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_data_q  <= '0;
         rd_vld_q   <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_vld_q   <= rd_vld_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign RdData       = rd_data_q;
   assign RdData_Valid = rd_vld_q;
   assign Addr_Err     = addr_err_q;

   for (genvar g = 0; g < NUM_EXPOSED; g++) begin : g_expose
      assign REG_OUT[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
   end

`ifdef REGFILE_PARITY_EN
   logic [REG_NUM-1:0] par_q;
   logic               par_err_q, par_err_d;
   logic               rd_par_bad;

   // The stored bit makes the data plus parity even, so for a healthy entry it
   // equals the XOR reduction of the data.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         par_q <= '0;
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (wr_sel[i]) begin
               par_q[i] <= (^WrData) ^ Par_Flip;
            end
         end
      end
   end

   always_comb begin
      rd_par_bad = 1'b0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (RdAddr == ADDR_WIDTH'(i)) begin
            rd_par_bad = (^mem_q[i]) ^ par_q[i];
         end
      end
      par_err_d = RdEn && rd_hit && rd_par_bad;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end

   assign Parity_Err = par_err_q;
`endif

endmodule

// File: tb/tb_regfile_dual_port.sv
module tb_regfile_dual_port;

   localparam int DW   = 8;
   localparam int NREG = 12;
   localparam int AW   = 4;
   localparam int NEXP = 6;
   localparam logic [NREG-1:0] PROT = 12'h001;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              WrEn = 1'b0;
   logic [AW-1:0]     WrAddr = '0;
   logic [DW-1:0]     WrData = '0;
   logic              RdEn = 1'b0;
   logic [AW-1:0]     RdAddr = '0;
   logic [DW-1:0]     RdData;
   logic              RdData_Valid;
   logic              Addr_Err;
   logic [NEXP*DW-1:0] REG_OUT;
`ifdef REGFILE_PARITY_EN
   logic              Par_Flip = 1'b0;
   logic              Parity_Err;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [DW-1:0] mem_m [16];
   logic          par_bad_m [16];
   logic [DW-1:0] exp_rd;
   logic          exp_vld;
   logic          exp_err;
   logic          exp_perr;

   regfile_dual_port #(
      .DATA_WIDTH (DW),
      .REG_NUM    (NREG),
      .ADDR_WIDTH (AW),
      .NUM_EXPOSED(NEXP),
      .WR_PROTECT (PROT)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .WrEn        (WrEn),
      .WrAddr      (WrAddr),
      .WrData      (WrData),
      .RdEn        (RdEn),
      .RdAddr      (RdAddr),
      .RdData      (RdData),
      .RdData_Valid(RdData_Valid),
      .Addr_Err    (Addr_Err),
      .REG_OUT     (REG_OUT)
`ifdef REGFILE_PARITY_EN
      ,
      .Par_Flip    (Par_Flip),
      .Parity_Err  (Parity_Err)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [NEXP*DW-1:0] model_regout();
      logic [NEXP*DW-1:0] r;
      for (int i = 0; i < NEXP; i++) r[i*DW +: DW] = mem_m[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         mem_m[i]     = '0;
         par_bad_m[i] = 1'b0;
      end
      exp_rd   = '0;
      exp_vld  = 1'b0;
      exp_err  = 1'b0;
      exp_perr = 1'b0;
   endtask

   // Drive one clock cycle of requests and advance the model. Returns 1 ns
   // after the edge with the requests deasserted.
   task automatic step(input logic we, input int wa, input logic [DW-1:0] wd,
                       input logic re, input int ra);
      logic wr_ok;
      WrEn   = we;
      WrAddr = AW'(wa);
      WrData = wd;
      RdEn   = re;
      RdAddr = AW'(ra);
      @(posedge CLK);
      wr_ok   = we && (wa < NREG) && !PROT[wa];
      exp_vld = re;
      if (re) exp_rd = (ra < NREG) ? mem_m[ra] : '0;
      exp_perr = re && (ra < NREG) && par_bad_m[ra];
      exp_err  = (we && !wr_ok) || (re && (ra >= NREG));
      if (wr_ok) begin
         mem_m[wa] = wd;
`ifdef REGFILE_PARITY_EN
         par_bad_m[wa] = Par_Flip;
`endif
      end
      #1;
      WrEn = 1'b0;
      RdEn = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      model_reset();
      checks++;
      if (RdData !== 8'h00 || RdData_Valid !== 1'b0 || Addr_Err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got rd=%h vld=%b err=%b, want 00/0/0", RdData, RdData_Valid, Addr_Err);
      end
      RST = 1'b0;
      for (int a = 0; a < NREG; a++) begin
         step(1'b0, 0, 8'h00, 1'b1, a);
         checks++;
         if (RdData !== 8'h00 || RdData_Valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_read[%0d]: got rd=%h vld=%b, want 00/1", a, RdData, RdData_Valid);
         end
      end
      checks++;
      if (REG_OUT !== 48'h0) begin
         errors++;
         $display("FAIL reset_regout: got %h, want 0", REG_OUT);
      end
   endtask

   task automatic test_write_readback();
      step(1'b1, 3, 8'hA5, 1'b0, 0);
      checks++;
      if (REG_OUT[31:24] !== 8'hA5 || Addr_Err !== 1'b0) begin
         errors++;
         $display("FAIL wr_expose: got regout[31:24]=%h err=%b, want a5/0", REG_OUT[31:24], Addr_Err);
      end
      step(1'b0, 0, 8'h00, 1'b1, 3);
      checks++;
      if (RdData !== 8'hA5 || RdData_Valid !== 1'b1 || Addr_Err !== 1'b0) begin
         errors++;
         $display("FAIL wr_readback: got rd=%h vld=%b err=%b, want a5/1/0", RdData, RdData_Valid, Addr_Err);
      end
      step(1'b0, 0, 8'h00, 1'b0, 0);
      checks++;
      if (RdData !== 8'hA5 || RdData_Valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_hold: got rd=%h vld=%b, want a5/0", RdData, RdData_Valid);
      end
   endtask

   task automatic test_collision();
      step(1'b1, 5, 8'h11, 1'b0, 0);
      step(1'b1, 5, 8'h22, 1'b1, 5);
      checks++;
      if (RdData !== 8'h11 || RdData_Valid !== 1'b1) begin
         errors++;
         $display("FAIL collision_old: got rd=%h vld=%b, want 11/1", RdData, RdData_Valid);
      end
      step(1'b0, 0, 8'h00, 1'b1, 5);
      checks++;
      if (RdData !== 8'h22 || RdData_Valid !== 1'b1) begin
         errors++;
         $display("FAIL collision_new: got rd=%h vld=%b, want 22/1", RdData, RdData_Valid);
      end
   endtask

   task automatic test_protect_range();
      step(1'b1, 0, 8'hFF, 1'b0, 0);
      checks++;
      if (Addr_Err !== 1'b1 || REG_OUT[7:0] !== 8'h00) begin
         errors++;
         $display("FAIL prot_write: got err=%b entry0=%h, want 1/00", Addr_Err, REG_OUT[7:0]);
      end
      step(1'b0, 0, 8'h00, 1'b1, 0);
      checks++;
      if (Addr_Err !== 1'b0 || RdData !== 8'h00) begin
         errors++;
         $display("FAIL prot_pulse_end: got err=%b rd=%h, want 0/00", Addr_Err, RdData);
      end
      step(1'b0, 0, 8'h00, 1'b1, 13);
      checks++;
      if (RdData !== 8'h00 || RdData_Valid !== 1'b1 || Addr_Err !== 1'b1) begin
         errors++;
         $display("FAIL oor_read: got rd=%h vld=%b err=%b, want 00/1/1", RdData, RdData_Valid, Addr_Err);
      end
      step(1'b1, 14, 8'h77, 1'b1, 15);
      checks++;
      if (Addr_Err !== 1'b1 || RdData_Valid !== 1'b1) begin
         errors++;
         $display("FAIL both_reject: got err=%b vld=%b, want 1/1", Addr_Err, RdData_Valid);
      end
      step(1'b0, 0, 8'h00, 1'b0, 0);
      checks++;
      if (Addr_Err !== 1'b0) begin
         errors++;
         $display("FAIL both_reject_single: got err=%b, want 0", Addr_Err);
      end
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < NREG; a++) step(1'b1, a, 8'(a * 17 + 3), 1'b0, 0);
      for (int a = 0; a < NREG; a++) begin
         step(1'b0, 0, 8'h00, 1'b1, a);
         checks++;
         if (RdData !== exp_rd || RdData_Valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_read[%0d]: got rd=%h vld=%b, want %h/1", a, RdData, RdData_Valid, exp_rd);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 8'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
         checks++;
         if (RdData !== exp_rd || RdData_Valid !== exp_vld || Addr_Err !== exp_err ||
             REG_OUT !== model_regout()) begin
            errors++;
            $display("FAIL random[%0d]: got rd=%h vld=%b err=%b out=%h, want %h/%b/%b/%h",
                     n, RdData, RdData_Valid, Addr_Err, REG_OUT, exp_rd, exp_vld, exp_err, model_regout());
         end
      end
   endtask

   task automatic test_async_reset();
      step(1'b1, 2, 8'h3C, 1'b1, 5);
      checks++;
      if (REG_OUT[23:16] !== 8'h3C || RdData_Valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: got entry2=%h vld=%b, want 3c/1", REG_OUT[23:16], RdData_Valid);
      end
      RdEn   = 1'b1;
      RdAddr = 4'd2;
      WrEn   = 1'b1;
      WrAddr = 4'd2;
      WrData = 8'h99;
      #2;
      RST = 1'b1;
      #1;
      model_reset();
      checks++;
      if (RdData !== 8'h00 || RdData_Valid !== 1'b0 || Addr_Err !== 1'b0 || REG_OUT !== 48'h0) begin
         errors++;
         $display("FAIL async_clear: got rd=%h vld=%b err=%b out=%h, want all 0",
                  RdData, RdData_Valid, Addr_Err, REG_OUT);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (RdData_Valid !== 1'b0 || REG_OUT !== 48'h0) begin
         errors++;
         $display("FAIL async_hold: got vld=%b out=%h, want 0/0", RdData_Valid, REG_OUT);
      end
      RdEn = 1'b0;
      WrEn = 1'b0;
      RST  = 1'b0;
      step(1'b0, 0, 8'h00, 1'b1, 2);
      checks++;
      if (RdData !== 8'h00 || RdData_Valid !== 1'b1) begin
         errors++;
         $display("FAIL async_after: got rd=%h vld=%b, want 00/1", RdData, RdData_Valid);
      end
   endtask

`ifdef REGFILE_PARITY_EN
   task automatic test_parity();
      Par_Flip = 1'b1;
      step(1'b1, 4, 8'h0F, 1'b0, 0);
      Par_Flip = 1'b0;
      step(1'b0, 0, 8'h00, 1'b1, 4);
      checks++;
      if (Parity_Err !== 1'b1 || RdData_Valid !== 1'b1 || RdData !== 8'h0F) begin
         errors++;
         $display("FAIL parity_bad: got perr=%b vld=%b rd=%h, want 1/1/0f", Parity_Err, RdData_Valid, RdData);
      end
      step(1'b1, 4, 8'h07, 1'b0, 0);
      step(1'b0, 0, 8'h00, 1'b1, 4);
      checks++;
      if (Parity_Err !== 1'b0 || RdData !== 8'h07) begin
         errors++;
         $display("FAIL parity_good: got perr=%b rd=%h, want 0/07", Parity_Err, RdData);
      end
      step(1'b0, 0, 8'h00, 1'b0, 0);
      checks++;
      if (Parity_Err !== exp_perr) begin
         errors++;
         $display("FAIL parity_idle: got perr=%b, want %b", Parity_Err, exp_perr);
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_write_readback();
      test_collision();
      test_protect_range();
      test_back_to_back();
      test_random();
      test_async_reset();
`ifdef REGFILE_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time bound so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_dual_port.md
Name: regfile_dual_port

Overview:
- Parametrised register file for the system control path: one write port and one independent read port, with configurable depth and width.
- Provides a registered read with a valid strobe and per-entry write protection.
- Reports an error for out-of-range or protected accesses.
- Exposes the low NUM_EXPOSED entries as a flat bus for the ALU/UART configuration consumers.

Parameters:
- DATA_WIDTH, 8, bits per entry.
- REG_NUM, 12, number of implemented entries (2..2**ADDR_WIDTH).
- ADDR_WIDTH, 4, address bits on both ports.
- NUM_EXPOSED, 6, number of low entries driven onto REG_OUT (1..REG_NUM).
- WR_PROTECT, 0, REG_NUM-bit mask. Bit i=1 makes entry i read-only from the write port.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- WrEn  in  1  write request.
- WrAddr  in  ADDR_WIDTH  write address.
- WrData  in  DATA_WIDTH  write data.
- RdEn  in  1  read request.
- RdAddr  in  ADDR_WIDTH  read address.
- RdData  out  DATA_WIDTH  registered read data.
- RdData_Valid  out  1  one-cycle strobe, RdData updated this cycle.
- Addr_Err  out  1  one-cycle strobe, previous-cycle access was rejected.
- REG_OUT  out  NUM_EXPOSED*DATA_WIDTH  entry i on bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (RST=1, asynchronous):
  - all entries, RdData, RdData_Valid and Addr_Err go to 0 immediately.
  - Reset mid-access discards that access: no write occurs and no strobe is produced.
- Write:
  - Entry WrAddr takes WrData on the edge where WrEn=1, provided WrAddr<REG_NUM and WR_PROTECT[WrAddr]=0.
  - Otherwise the array is unchanged and the write is rejected.
- Read, latency 1:
  - On the edge where RdEn=1, RdData <= entry RdAddr (or 0 if RdAddr>=REG_NUM) and RdData_Valid <= 1.
  - When RdEn=0, RdData_Valid <= 0 and RdData holds its last value; it is not zeroed.
- Out-of-range read: RdData <= 0, RdData_Valid <= 1, and the read is rejected.
- Simultaneous WrEn and RdEn are both serviced in the same cycle.
  - Same address: the read returns the old contents (read-before-write).
  - The new value is visible to reads issued on the next cycle.
- Addr_Err <= 1 for exactly one cycle after any cycle containing a rejected write or a rejected read. Both rejected in one cycle still gives a single pulse. Otherwise Addr_Err <= 0.
- REG_OUT is combinational from the array.
  - Reflects a write on the same edge the entry updates.
  - Protected entries therefore always read as their reset value 0.
- Back-to-back reads on consecutive cycles give consecutive valid strobes with no bubble.
- No internal FSM beyond the output registers. Throughput is one read and one write per cycle.
- Elaboration check: NUM_EXPOSED>REG_NUM or REG_NUM>2**ADDR_WIDTH must stop elaboration ($error in generate).

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- When defined:
  - each entry stores an extra even-parity bit computed from WrData at write time;
  - on every in-range read the stored bit is checked against recomputed parity;
  - a mismatch raises output Parity_Err (1 bit, registered, aligned with RdData_Valid, one-cycle pulse, reset 0);
  - a test-only input Par_Flip (1 bit) inverts the stored parity bit of the entry written that cycle.
- When undefined: no parity storage, and the Parity_Err and Par_Flip ports do not exist.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset check: assert RST for 3 cycles, release, then read addresses 0..11 -> every RdData=8'h00 with RdData_Valid high one cycle after each RdEn, and REG_OUT=48'h0.
- Write/readback with exposure: write 8'hA5 to address 3, then read address 3 -> RdData=8'hA5 one cycle later, REG_OUT[31:24]=8'hA5 right after the write edge, and Addr_Err stays 0.
- Same-cycle collision: entry 5=8'h11; in one cycle WrEn to address 5 with 8'h22 and RdEn at address 5 -> RdData=8'h11; read again next cycle -> RdData=8'h22.
- Range and protection: run with WR_PROTECT=12'h001.
  - write 8'hFF to address 0 -> entry unchanged at 8'h00 and Addr_Err pulses one cycle;
  - read address 13 -> RdData=8'h00, RdData_Valid=1, Addr_Err pulses one cycle.
- Async reset mid-access: write 8'h3C to address 2, then assert RST between clock edges while RdEn is high -> outputs clear immediately with no valid strobe; after release, read address 2 returns 8'h00.
- Parity (REGFILE_PARITY_EN defined): write 8'h0F to address 4 with Par_Flip=1, then read address 4 -> Parity_Err=1 coincident with RdData_Valid; a normal write followed by a read -> Parity_Err=0.
